shift_right4: RTL and testbench



---
 rtl/shift_right4.sv | 33 +++
 tb/tb_shift_right4.sv | 126 ++++++++++++
 2 files changed

// File: rtl/shift_right4.sv
// Parallel-load, logical right-shift register with enable and asynchronous clear.
// Load takes priority over shift; shifting fills the MSB with zero and never wraps.
module shift_right4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             load,
    input  logic             ena,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    assign w_shifted = {1'b0, r_q[WIDTH-1:1]};

    // NOTE: areset sits in the sensitivity list so q clears without a clock edge;
    // the state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= data;
        end else if (ena) begin
            r_q <= w_shifted;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_shift_right4.sv
// Self-checking bench for shift_right4: directed corner cases followed by random
// load/shift/reset traffic compared against an arithmetic reference model.
module tb_shift_right4;

    localparam int WIDTH = 4;

    logic             clk;
    logic             areset;
    logic             load;
    logic             ena;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] q;

    int unsigned model;
    int checks;
    int failures;

    shift_right4 #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .areset (areset),
        .load   (load),
        .ena    (ena),
        .data   (data),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: q=%b expected=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs away from the edge, let one rising edge pass, update the
    // model from the rules (divide by two for a shift), then compare on negedge.
    task automatic cycle(input string tag, input logic l, input logic e,
                         input logic [WIDTH-1:0] d);
        load = l;
        ena  = e;
        data = d;
        @(posedge clk);
        if (areset)   model = 0;
        else if (l)   model = d;
        else if (e)   model = model / 2;
        @(negedge clk);
        check(tag, q, model[WIDTH-1:0]);
    endtask

    // Raise areset shortly after the falling edge, well before the next rising edge.
    task automatic async_clear(input string tag);
        #2 areset = 1'b1;
        model = 0;
        #1 check(tag, q, '0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model    = 0;
        areset   = 1'b1;
        load     = 1'b0;
        ena      = 1'b0;
        data     = '0;

        @(negedge clk);
        check("reset_state", q, '0);
        areset = 1'b0;

        // Asynchronous clear with no clock edge from 1010.
        cycle("load_1010", 1'b1, 1'b0, 4'b1010);
        async_clear("async_clear_1010");
        areset = 1'b0;

        // Load, then shift to zero and confirm no wrap.
        cycle("load_0110", 1'b1, 1'b0, 4'b0110);
        cycle("shift1_0011", 1'b0, 1'b1, 4'b1111);
        cycle("shift2_0001", 1'b0, 1'b1, 4'b1111);
        cycle("shift3_0000", 1'b0, 1'b1, 4'b1111);
        cycle("shift4_nowrap", 1'b0, 1'b1, 4'b1111);

        // Load beats ena.
        cycle("load_0110_b", 1'b1, 1'b0, 4'b0110);
        cycle("load_wins", 1'b1, 1'b1, 4'b1001);

        // Shift / hold / shift from 1111.
        cycle("load_1111", 1'b1, 1'b0, 4'b1111);
        cycle("shift_0111", 1'b0, 1'b1, 4'b0000);
        cycle("hold_0111", 1'b0, 1'b0, 4'b1010);
        cycle("shift_0011", 1'b0, 1'b1, 4'b0000);

        // Reset mid-shift; areset overrides load while held high.
        cycle("load_1100", 1'b1, 1'b0, 4'b1100);
        cycle("midshift_0110", 1'b0, 1'b1, 4'b0000);
        async_clear("midshift_clear");
        cycle("rst_over_load1", 1'b1, 1'b1, 4'b1111);
        cycle("rst_over_load2", 1'b1, 1'b0, 4'b1111);
        areset = 1'b0;
        cycle("shift_from_zero", 1'b0, 1'b1, 4'b1111);
        cycle("load_after_rst", 1'b1, 1'b0, 4'b1011);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic l, e;
            logic [WIDTH-1:0] d;
            if ($urandom_range(0, 19) == 0) begin
                async_clear("rand_async_clear");
                if ($urandom_range(0, 1) == 0) areset = 1'b0;
            end else begin
                areset = 1'b0;
            end
            l = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 2) != 0);
            d = WIDTH'($urandom);
            cycle("random", l, e, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
